// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with parity/stop checking and a
// single-word valid/ready output holding register with overrun detection.
`timescale 1ns/1ps

module uart_rx_core #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RsRx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = 4;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_sync;
  logic                   rx_prev;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [TICK_W-1:0]      tick_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   ferr_q;
  logic                   perr_q;
  logic                   sample;
  logic                   complete;
  logic                   frame_bad;
  logic                   transfer;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the line idles high, so these flops reset to 1; resetting to 0
      // would fake a falling edge right after reset is released.
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what builds a real shift chain.
      rx_meta <= RsRx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Free-running divider producing a one-cycle oversample tick every DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      tick    <= 1'b0;
    end
  end

  // Mid-bit sample point for data, parity and stop bits.
  assign sample    = tick && (tick_cnt == LAST_TICK);
  assign complete  = (state == S_STOP) && sample && (bit_cnt == LAST_STOP);
  assign frame_bad = ferr_q | ~rx_sync;
  assign transfer  = valid_out & ready_in;
  assign busy      = (state != S_IDLE);

  // Frame receive FSM: start validation, data shift, parity and stop checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= S_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              state    <= rx_sync ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_PARITY: begin
          if (sample) begin
            tick_cnt <= '0;
            // Odd mode wants the XOR of data and parity bit to be 1, even wants 0.
            perr_q   <= (PARITY == 1) ? ~(^shift_reg ^ rx_sync) : (^shift_reg ^ rx_sync);
            state    <= S_STOP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_STOP: begin
          if (sample) begin
            tick_cnt <= '0;
            if (!rx_sync) ferr_q <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= frame_bad ? S_WAIT_HIGH : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must return high before a new frame may start.
          if (rx_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output holding register: load on completion, drop with overrun when still held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (complete) begin
      if (!valid_out || transfer) begin
        data_out    <= shift_reg;
        valid_out   <= 1'b1;
        frame_err   <= frame_bad;
        parity_err  <= perr_q;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (transfer) begin
      valid_out   <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 100_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line rate in baud.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-006 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit; even, at least 8.
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-009 SHALL have port RsRx, input, 1 bit, meaning asynchronous serial line; idle level is high.
REQ-010 SHALL have port data_out, output, DATA_BITS bits, meaning the received word, LSB received first.
REQ-011 SHALL have port valid_out, output, 1 bit, meaning data_out and the error flags hold an undelivered frame.
REQ-012 SHALL have port ready_in, input, 1 bit, meaning the consumer accepts the word this cycle.
REQ-013 SHALL have port frame_err, output, 1 bit, meaning a stop bit of the held frame sampled low.
REQ-014 SHALL have port parity_err, output, 1 bit, meaning the held frame's parity mismatched; it is always 0 when PARITY=0.
REQ-015 SHALL have port overrun_err, output, 1 bit, meaning at least one frame was dropped while the current word was held.
REQ-016 SHALL have port busy, output, 1 bit, meaning the FSM is in any state other than IDLE.

Function
REQ-017 SHALL pass RsRx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-018 SHALL generate a one-cycle tick every DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE) cycles, with integer division and a minimum DIV of 1; the tick counter runs freely.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE: on a synchronized falling edge, SHALL enter START and clear the tick-in-bit and bit counters.
REQ-021 START: on tick count OVERSAMPLE/2-1 (mid-bit), a high line SHALL return to IDLE as a glitch with no output; a low line SHALL enter DATA with the tick counter cleared.
REQ-022 DATA: SHALL sample once per OVERSAMPLE ticks at mid-bit, shift LSB-first, and after DATA_BITS samples go to PARITY if PARITY != 0, else to STOP.
REQ-023 PARITY: SHALL sample one bit; odd mode requires XOR(data, parity bit) = 1, and even mode requires it to be 0.
REQ-024 STOP: SHALL sample STOP_BITS bits at mid-bit; any low sample SHALL mark a frame error.
REQ-025 SHALL complete the frame at the last stop sample; it SHALL then go to IDLE, or to WAIT_HIGH if a frame error occurred.
REQ-026 WAIT_HIGH: SHALL remain until the synchronized line is high, then go to IDLE, so that a break does not retrigger.
REQ-027 On frame completion, SHALL register data_out, frame_err, parity_err, and valid_out=1 on the next cycle.
REQ-028 Frames with errors SHALL still be delivered, with their flags set.
REQ-029 Handshake: transfer SHALL occur when valid_out && ready_in; valid_out, frame_err, parity_err, and overrun_err SHALL clear on the next cycle.
REQ-030 data_out and the flags SHALL remain stable while valid_out=1 and no transfer occurs.
REQ-031 Completion while valid_out=1 and ready_in=0 SHALL drop the new frame, keep the held word, and set overrun_err.
REQ-032 Completion in the same cycle as a transfer SHALL load the new frame, keep valid_out=1, and leave overrun_err=0.
REQ-033 Reception SHALL continue regardless of valid_out; ready_in SHALL never stall the line.

Reset
REQ-034 reset=1 SHALL immediately clear data_out, valid_out, frame_err, parity_err, overrun_err, busy, all counters and the shift register, force state IDLE, and set the synchronizer flops to 1.
REQ-035 Reset mid-frame SHALL discard the partial frame; the first falling edge after reset deassertion SHALL start a new frame.

Verification
REQ-036 Bench SHALL use CLOCK_RATE=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 (DIV=10, 160 cycles per bit) for all scenarios.
REQ-037 With 8N1, send 0xA5 with ready_in=1 -> data_out=0xA5, valid_out high exactly 1 cycle, all error flags 0.
REQ-038 With PARITY=2, send 0x3C with parity bit 1 -> data_out=0x3C, parity_err=1, frame_err=0; repeat with parity bit 0 -> parity_err=0.
REQ-039 Send 0x00 with the stop bit low for 3 bit times -> frame_err=1; busy stays high until the line is high, and no second frame is produced.
REQ-040 Pulse the line low for 4 ticks (40 cycles) -> busy returns low and valid_out never rises.
REQ-041 With ready_in=0, send 0x11 then 0x22 -> data_out=0x11, overrun_err=1; then ready_in=1 for 1 cycle -> valid_out=0 and overrun_err=0 on the next cycle.
REQ-042 Assert reset for 2 cycles during data bit 3 -> all outputs are 0 at once; then send 0x5A -> data_out=0x5A with no errors.
